// File: rtl/fetch_pc_gen_if.sv
// rtl/fetch_pc_gen_if.sv - predictor / retire / fetch-stage signal bundle for fetch_pc_gen
//
// Purpose: groups every non-clock signal of fetch_pc_gen so the producer side
// (predictor, retire redirect, fetch stage) and the PC generator share one bundle.
//
// Signals:
//   PC              fetch PC presented to the predictor
//   bp_next_PC      predictor next_PC for PC
//   bp_predictions  predictor per-way taken bits for PC
//   redirect_valid  retire redirect request
//   redirect_PC     redirect target (low two bits ignored)
//   deq_ready       fetch stage accepts the head bundle
//   out_valid       head bundle valid
//   out_PC          head bundle fetch PC
//   out_predictions head bundle per-way taken bits
//   out_next_PC     head bundle predicted successor
//   full            queue holds DEPTH bundles
//   count           queue occupancy
//
// Modports: slave = fetch_pc_gen, master = surrounding pipeline / bench.

interface fetch_pc_gen_if #(
  parameter int XLEN  = 32,
  parameter int WAYS  = 2,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] PC;
  logic [XLEN-1:0] bp_next_PC;
  logic [WAYS-1:0] bp_predictions;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_PC;
  logic            deq_ready;
  logic            out_valid;
  logic [XLEN-1:0] out_PC;
  logic [WAYS-1:0] out_predictions;
  logic [XLEN-1:0] out_next_PC;
  logic            full;
  logic [CW-1:0]   count;

  modport slave (
    input  bp_next_PC, bp_predictions, redirect_valid, redirect_PC, deq_ready,
    output PC, out_valid, out_PC, out_predictions, out_next_PC, full, count
  );

  modport master (
    output bp_next_PC, bp_predictions, redirect_valid, redirect_PC, deq_ready,
    input  PC, out_valid, out_PC, out_predictions, out_next_PC, full, count
  );
endinterface

// File: rtl/fetch_pc_gen.sv
// rtl/fetch_pc_gen.sv - fetch PC generator and fetch target queue
//
// Purpose: owns the fetch PC, presents it to the branch predictor every cycle,
// captures {PC, predictions, next_PC} into a DEPTH-entry FIFO of fetch bundles
// for the instruction-fetch stage, and flushes/restarts on a retire redirect.
//
// Ports:
//   clock           single clock, all state on posedge
//   reset           synchronous, active-high; overrides redirect and traffic
//   bus (slave)     fetch_pc_gen_if bundle (predictor, redirect, head outputs)
//   perf_redirects  (FETCH_PERF_EN only) cycles with redirect_valid, wraps at 2^32
//   perf_stalls     (FETCH_PERF_EN only) cycles with full && !redirect_valid
//
// Optional feature macro: FETCH_PERF_EN (performance counters).

module fetch_pc_gen #(
  parameter int                   XLEN     = 32,
  parameter int                   WAYS     = 2,
  parameter int                   DEPTH    = 4,
  parameter logic [XLEN-1:0]      RESET_PC = '0
) (
  input  logic                    clock,
  input  logic                    reset,
  fetch_pc_gen_if.slave           bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]             perf_redirects,
  output logic [31:0]             perf_stalls
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Architectural fetch PC and queue bookkeeping.
  logic [XLEN-1:0] r_pc;
  logic [AW-1:0]   r_head;
  logic [AW-1:0]   r_tail;
  logic [CW-1:0]   r_count;

  // Bundle storage, split per field.
  logic [XLEN-1:0] r_mem_pc   [DEPTH];
  logic [WAYS-1:0] r_mem_pred [DEPTH];
  logic [XLEN-1:0] r_mem_npc  [DEPTH];

  logic            w_full;
  logic            w_valid;
  logic            w_enq;
  logic            w_deq;
  logic [XLEN-1:0] w_redirect_pc;
  logic            w_unused_lsb;

  // Status is derived from the registered count only, so full/out_valid never
  // depend combinationally on this cycle's deq_ready or redirect_valid.
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_valid = (r_count != '0);

  // A same-cycle dequeue does not free a slot for enqueue: full is judged on
  // the state at the start of the cycle.
  assign w_enq = !bus.redirect_valid && !w_full;
  assign w_deq = w_valid && bus.deq_ready && !bus.redirect_valid;

  // Fetch is word aligned; the target's low two bits are dropped.
  assign w_redirect_pc = {bus.redirect_PC[XLEN-1:2], 2'b00};
  assign w_unused_lsb  = ^bus.redirect_PC[1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc    <= RESET_PC;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (bus.redirect_valid) begin
      r_pc    <= w_redirect_pc;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) begin
        r_tail <= r_tail + AW'(1);
        r_pc   <= bus.bp_next_PC;
      end
      if (w_deq) begin
        r_head <= r_head + AW'(1);
      end
      r_count <= r_count + CW'(w_enq) - CW'(w_deq);
    end
  end

  // Storage carries no reset; entries are only observed while out_valid is set.
  always_ff @(posedge clock) begin
    if (!reset && w_enq) begin
      r_mem_pc[r_tail]   <= r_pc;
      r_mem_pred[r_tail] <= bus.bp_predictions;
      r_mem_npc[r_tail]  <= bus.bp_next_PC;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_redirects;
  logic [31:0] r_perf_stalls;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_perf_redirects <= '0;
      r_perf_stalls    <= '0;
    end else begin
      if (bus.redirect_valid) begin
        r_perf_redirects <= r_perf_redirects + 32'd1;
      end
      if (w_full && !bus.redirect_valid) begin
        r_perf_stalls <= r_perf_stalls + 32'd1;
      end
    end
  end

  assign perf_redirects = r_perf_redirects;
  assign perf_stalls    = r_perf_stalls;
`endif

  assign bus.PC              = r_pc;
  assign bus.out_valid       = w_valid;
  assign bus.full            = w_full;
  assign bus.count           = r_count;
  assign bus.out_PC          = r_mem_pc[r_head];
  assign bus.out_predictions = r_mem_pred[r_head];
  assign bus.out_next_PC     = r_mem_npc[r_head];
endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb/tb_fetch_pc_gen.sv - self-checking bench for fetch_pc_gen

module tb_fetch_pc_gen;
  localparam int XLEN  = 32;
  localparam int WAYS  = 2;
  localparam int DEPTH = 4;

  logic clock;
  logic reset;
  logic special;

  fetch_pc_gen_if #(.XLEN(XLEN), .WAYS(WAYS), .DEPTH(DEPTH)) bus ();

`ifdef FETCH_PERF_EN
  logic [31:0] perf_redirects;
  logic [31:0] perf_stalls;
`endif

  fetch_pc_gen #(.XLEN(XLEN), .WAYS(WAYS), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
`ifdef FETCH_PERF_EN
    ,
    .perf_redirects (perf_redirects),
    .perf_stalls    (perf_stalls)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Predictor model: next = PC+8, predictions = {PC[3],PC[4]}; in special mode
  // PC 0x8 predicts taken way 0 to 0x400.
  function automatic logic [WAYS+XLEN-1:0] pred_fn(input logic [XLEN-1:0] pc, input logic sp);
    if (sp && pc == 32'h8) return {2'b01, 32'h400};
    return {pc[3], pc[4], pc + 32'd8};
  endfunction

  always_comb {bus.bp_predictions, bus.bp_next_PC} = pred_fn(bus.PC, special);

  typedef struct {
    logic        rst;
    logic        redir;
    logic        deq;
    logic        spec;
    logic [31:0] rpc;
    logic [31:0] e_pc;
    logic [2:0]  e_cnt;
    logic        e_v;
    logic        e_f;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [1:0]  pred;
    logic [31:0] npc;
  } bun_t;

  vec_t tbl[$];
  bun_t sb[$];

  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc;
  int          m_count;
  int unsigned m_predir;
  int unsigned m_pstall;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic redir, input logic deq, input logic spec,
                              input logic [31:0] rpc, input logic [31:0] e_pc, input int e_cnt,
                              input logic e_v, input logic e_f);
    vec_t v;
    v.rst = rst; v.redir = redir; v.deq = deq; v.spec = spec; v.rpc = rpc;
    v.e_pc = e_pc; v.e_cnt = 3'(e_cnt); v.e_v = e_v; v.e_f = e_f;
    return v;
  endfunction

  // Scoreboard/model step for one cycle; called after inputs have settled.
  task automatic model_step(input vec_t v);
    logic        m_full;
    logic        m_valid;
    logic        enq;
    logic        deq;
    bun_t        b;
    bun_t        h;
    logic [33:0] p;
    m_full  = (m_count == DEPTH);
    m_valid = (m_count != 0);
    if (v.rst) begin
      sb.delete();
      m_pc = 32'h0; m_count = 0; m_predir = 0; m_pstall = 0;
    end else if (v.redir) begin
      m_predir++;
      sb.delete();
      m_pc = {v.rpc[31:2], 2'b00};
      m_count = 0;
    end else begin
      if (m_full) m_pstall++;
      deq = m_valid && v.deq;
      enq = !m_full;
      if (deq) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_underflow: got empty scoreboard expected entry");
        end else begin
          h = sb.pop_front();
          check("out_PC", bus.out_PC, h.pc);
          check("out_predictions", 32'(bus.out_predictions), 32'(h.pred));
          check("out_next_PC", bus.out_next_PC, h.npc);
        end
      end
      if (enq) begin
        p = pred_fn(m_pc, v.spec);
        b.pc = m_pc; b.pred = p[33:32]; b.npc = p[31:0];
        sb.push_back(b);
        m_pc = b.npc;
      end
      m_count = m_count + int'(enq) - int'(deq);
    end
  endtask

  initial begin
    logic [31:0] pc_before;

    reset = 1'b1; special = 1'b0;
    bus.redirect_valid = 1'b0; bus.redirect_PC = '0; bus.deq_ready = 1'b0;
    m_pc = 0; m_count = 0; m_predir = 0; m_pstall = 0;

    // Streaming with deq_ready=1: one bundle per cycle, count stays 1.
    tbl.push_back(mk(1,0,1,0,0, 32'h00,0,0,0));
    tbl.push_back(mk(0,0,1,0,0, 32'h08,1,1,0));
    tbl.push_back(mk(0,0,1,0,0, 32'h10,1,1,0));
    tbl.push_back(mk(0,0,1,0,0, 32'h18,1,1,0));
    tbl.push_back(mk(0,0,1,0,0, 32'h20,1,1,0));
    // Fill to full, stall, then drain one with no same-cycle enqueue.
    tbl.push_back(mk(1,0,0,0,0, 32'h00,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 32'h08,1,1,0));
    tbl.push_back(mk(0,0,0,0,0, 32'h10,2,1,0));
    tbl.push_back(mk(0,0,0,0,0, 32'h18,3,1,0));
    tbl.push_back(mk(0,0,0,0,0, 32'h20,4,1,1));
    tbl.push_back(mk(0,0,0,0,0, 32'h20,4,1,1));
    tbl.push_back(mk(0,0,1,0,0, 32'h20,3,1,0));
    tbl.push_back(mk(0,0,1,0,0, 32'h28,3,1,0));
    // Redirect with 3 queued, unaligned target.
    tbl.push_back(mk(0,1,1,0,32'h1002, 32'h1000,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 32'h1008,1,1,0));
    tbl.push_back(mk(0,0,1,0,0, 32'h1010,1,1,0));
    // Predicted-taken bundle {0x8, 01, 0x400}.
    tbl.push_back(mk(1,0,1,1,0, 32'h000,0,0,0));
    tbl.push_back(mk(0,0,1,1,0, 32'h008,1,1,0));
    tbl.push_back(mk(0,0,1,1,0, 32'h400,1,1,0));
    tbl.push_back(mk(0,0,1,1,0, 32'h408,1,1,0));
    tbl.push_back(mk(0,0,1,1,0, 32'h410,1,1,0));
    // Full queue, redirect together with deq_ready.
    tbl.push_back(mk(1,0,0,0,0, 32'h00,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 32'h08,1,1,0));
    tbl.push_back(mk(0,0,0,0,0, 32'h10,2,1,0));
    tbl.push_back(mk(0,0,0,0,0, 32'h18,3,1,0));
    tbl.push_back(mk(0,0,0,0,0, 32'h20,4,1,1));
    tbl.push_back(mk(0,0,0,0,0, 32'h20,4,1,1));
    tbl.push_back(mk(0,1,1,0,32'h2000, 32'h2000,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 32'h2008,1,1,0));
    tbl.push_back(mk(0,0,0,0,0, 32'h2010,2,1,0));
    // Reset during redirect with a non-empty queue.
    tbl.push_back(mk(1,1,1,0,32'h3000, 32'h00,0,0,0));
    tbl.push_back(mk(0,0,1,0,0, 32'h08,1,1,0));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clock);
      reset              = tbl[i].rst;
      bus.redirect_valid = tbl[i].redir;
      bus.redirect_PC    = tbl[i].rpc;
      bus.deq_ready      = tbl[i].deq;
      special            = tbl[i].spec;
      #1;
      model_step(tbl[i]);
      @(posedge clock);
      #1;
      check($sformatf("PC[%0d]", i), bus.PC, tbl[i].e_pc);
      check($sformatf("count[%0d]", i), 32'(bus.count), 32'(tbl[i].e_cnt));
      check($sformatf("out_valid[%0d]", i), 32'(bus.out_valid), 32'(tbl[i].e_v));
      check($sformatf("full[%0d]", i), 32'(bus.full), 32'(tbl[i].e_f));
      check($sformatf("model_PC[%0d]", i), bus.PC, m_pc);
`ifdef FETCH_PERF_EN
      check($sformatf("perf_redirects[%0d]", i), perf_redirects, m_predir);
      check($sformatf("perf_stalls[%0d]", i), perf_stalls, m_pstall);
`endif
    end

    // PC must not react combinationally to redirect_valid or deq_ready.
    @(negedge clock);
    pc_before = bus.PC;
    bus.redirect_valid = 1'b1;
    bus.redirect_PC    = 32'h5000;
    bus.deq_ready      = 1'b0;
    #2;
    check("PC_no_comb_redirect", bus.PC, pc_before);
    check("count_no_comb_redirect", 32'(bus.count), 32'd1);
    bus.deq_ready = 1'b1;
    #1;
    check("PC_no_comb_deq", bus.PC, pc_before);
    @(posedge clock);
    #1;
    check("PC_after_redirect", bus.PC, 32'h5000);
    check("out_valid_after_redirect", 32'(bus.out_valid), 32'd0);
    @(negedge clock);
    bus.redirect_valid = 1'b0;
    bus.deq_ready      = 1'b0;
    @(posedge clock);
    #1;
    check("first_bundle_valid", 32'(bus.out_valid), 32'd1);
    check("first_bundle_PC", bus.out_PC, 32'h5000);
    check("first_bundle_next", bus.out_next_PC, 32'h5008);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_pc_gen.md
# fetch_pc_gen

Fetch-side PC generator and fetch target queue sitting directly upstream of the branch predictor. It owns the architectural fetch PC and presents it to the predictor each cycle. It captures the predictor's `next_PC`/`predictions` pair into a small FIFO of fetch bundles for the instruction-fetch stage. On a mispredict/exception redirect from retire, it flushes all queued bundles and restarts fetch from the redirect target.

## Interface
Parameters:
- `DEPTH`, 4, number of fetch-bundle entries; power of two, ≥2
- `RESET_PC`, 0, fetch PC after reset; `XLEN` bits, low two bits zero

Ports:
- `clock`  in  1  single clock; all state updates on posedge
- `reset`  in  1  synchronous, active-high
- `PC`  out  `XLEN`  current fetch PC, driven to predictor `PC` input
- `bp_next_PC`  in  `XLEN`  predictor `next_PC` for current `PC`
- `bp_predictions`  in  `WAYS`  predictor `predictions` for current `PC`
- `redirect_valid`  in  1  retire-stage redirect request
- `redirect_PC`  in  `XLEN`  redirect target
- `deq_ready`  in  1  fetch stage accepts head bundle this cycle
- `out_valid`  out  1  head bundle valid
- `out_PC`  out  `XLEN`  head bundle fetch PC
- `out_predictions`  out  `WAYS`  head bundle per-way taken bits
- `out_next_PC`  out  `XLEN`  head bundle predicted successor PC
- `full`  out  1  queue holds `DEPTH` entries
- `count`  out  `$clog2(DEPTH)+1`  occupancy

## Operation
- State: `PC` register, `DEPTH`-entry storage of {PC, predictions, next_PC}, head/tail pointers (`$clog2(DEPTH)` bits, wrap modulo `DEPTH`), `count`.
- Reset: `PC`=`RESET_PC`, head=tail=0, `count`=0, `out_valid`=0, `full`=0. Outputs `out_PC`/`out_predictions`/`out_next_PC` are don't-care while `out_valid`=0.
- Enqueue condition: `!redirect_valid && !full`, with `full` sampled at start of cycle. A dequeue in the same cycle does not allow enqueue when full.
- On enqueue: write {`PC`, `bp_predictions`, `bp_next_PC`} at tail; tail++; `PC` <= `bp_next_PC`.
- Stall: no enqueue and no redirect. `PC` holds, and the predictor re-evaluates the same `PC`.
- Dequeue condition: `out_valid && deq_ready && !redirect_valid`. head++. `deq_ready` while empty is ignored.
- `count` next = `count` + enq − deq. Simultaneous enq and deq leaves `count` unchanged.
- Redirect has highest priority. It sets head=tail=0 and `count`=0, and sets `PC` <= {`redirect_PC`[XLEN-1:2], 2'b00}. No enqueue or dequeue occurs that cycle.
- `out_valid` = (`count` != 0). `full` = (`count` == `DEPTH`). Both are combinational from registered `count`.
- Head outputs are read combinationally from storage at head.
- `reset` asserted mid-operation overrides `redirect_valid` and all traffic.

## Timing
- Predictor path is combinational: `PC` → predictor → `bp_next_PC` captured at the next edge. This gives one bundle per cycle at full throughput.
- Enqueue-to-visible latency is 1 cycle: a bundle enqueued at edge N is at head at edge N when the queue was empty, so `out_valid` is high in cycle N+1.
- Redirect at edge N: `PC`=target and `out_valid`=0 in cycle N+1. The first post-redirect bundle is visible in cycle N+2.
- No combinational path from `deq_ready` or `redirect_valid` to `PC`.

## Configuration
- `FETCH_PERF_EN` defined: adds output `perf_redirects` (32 bits) and output `perf_stalls` (32 bits).
  - `perf_redirects` increments on each cycle with `redirect_valid`.
  - `perf_stalls` increments each cycle where `full && !redirect_valid`.
  - Both reset to 0 and wrap at 2^32.
- `FETCH_PERF_EN` undefined: these ports and counters are absent, and behaviour is otherwise identical.

## Test plan
- Reset with `RESET_PC`=0x0, predictor model `next_PC`=PC+8 (`WAYS`=2), `deq_ready`=1 → `out_PC` sequence 0x0, 0x8, 0x10… one per cycle; `count` stays 1.
- `deq_ready`=0 from reset → after 4 cycles `count`=4 and `full`=1, and `PC` holds 0x20. Raise `deq_ready` → first dequeued `out_PC`=0x0, and a new enqueue occurs only after `full` drops.
- Predictor returns `predictions`=2'b01, `next_PC`=0x400 for PC=0x8 → bundle {0x8, 01, 0x400}; the next bundle PC is 0x400.
- Queue holding 3 entries, `redirect_valid`=1 with `redirect_PC`=0x1002 → next cycle `count`=0, `out_valid`=0, `PC`=0x1000; the following bundle `out_PC`=0x1000.
- Redirect asserted in the same cycle as `deq_ready`=1 with a full queue → neither enqueue nor dequeue is applied, and the queue is empty afterwards.
- Reset asserted during redirect with a non-empty queue → `PC`=`RESET_PC`, `count`=0. With `FETCH_PERF_EN`, both perf counters read 0.
